// File: rtl/mio_rx_sched_if.sv
// Packet handshake bundle between the rx/reg requesters, the scheduler and the core.
// slave = scheduler side, master = requester/core side.
interface mio_rx_sched_if #(
   parameter int PW = 104
);
   logic          rx_access_in;
   logic [PW-1:0] rx_packet_in;
   logic          rx_wait_out;
   logic          reg_access_in;
   logic [PW-1:0] reg_packet_in;
   logic          reg_wait_out;
   logic          access_out;
   logic [PW-1:0] packet_out;
   logic          wait_in;

   modport slave (
      input  rx_access_in,
      input  rx_packet_in,
      output rx_wait_out,
      input  reg_access_in,
      input  reg_packet_in,
      output reg_wait_out,
      output access_out,
      output packet_out,
      input  wait_in
   );

   modport master (
      output rx_access_in,
      output rx_packet_in,
      input  rx_wait_out,
      output reg_access_in,
      output reg_packet_in,
      input  reg_wait_out,
      input  access_out,
      input  packet_out,
      output wait_in
   );
endinterface

// File: rtl/mio_rx_sched.sv
// Purpose: arbitrates rx and reg packets onto one core port, with amode address rewrite; MIO_SCHED_REGPRI_EN selects fixed reg priority.
// Latency: 1 cycle from acceptance to packet_out.
// Backpressure: output register holds while wait_in=1; requester waits are combinational.
module mio_rx_sched #(
   parameter int AW = 32,
   parameter int PW = 104
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          amode,
   input  logic [AW-1:0] dstaddr_base,
   input  logic [3:0]    addr_stride,
   input  logic [15:0]   burst_len,
   output logic [AW-1:0] addr_out,
   output logic          burst_done,
   mio_rx_sched_if.slave bus
);

   logic          load;
   logic          rx_sel;
   logic          reg_sel;
   logic          rx_acc;
   logic          reg_acc;
   logic          amode_q;
   logic          first_amode;
   logic          amode_beat;
   logic          last_beat;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_cur;
   logic [AW-1:0] addr_step;
   logic [15:0]   beat_q;
   logic [15:0]   beat_cur;
   logic [PW-1:0] rx_pkt_mod;

`ifdef MIO_SCHED_REGPRI_EN
   assign reg_sel = 1'b1;
   assign rx_sel  = ~bus.reg_access_in;
`else
   typedef enum logic {PRI_RX, PRI_REG} state_t;
   state_t state;

   // A lone requester is always selectable; priority only matters on contention.
   assign rx_sel  = (state == PRI_RX)  | ~bus.reg_access_in;
   assign reg_sel = (state == PRI_REG) | ~bus.rx_access_in;
`endif

   assign load    = ~bus.access_out | ~bus.wait_in;
   assign rx_acc  = bus.rx_access_in  & rx_sel  & load;
   assign reg_acc = bus.reg_access_in & reg_sel & load;

   assign bus.rx_wait_out  = ~load | ~rx_sel;
   assign bus.reg_wait_out = ~load | ~reg_sel;

   // First amode cycle uses the base directly so a beat accepted that cycle is addressed correctly.
   assign first_amode = amode & ~amode_q;
   assign addr_cur    = first_amode ? dstaddr_base : addr_q;
   assign beat_cur    = first_amode ? 16'd0 : beat_q;
   assign addr_step   = {{(AW-4){1'b0}}, addr_stride};
   assign amode_beat  = amode & rx_acc;
   assign last_beat   = (burst_len != 16'd0) && (beat_cur == (burst_len - 16'd1));
   assign burst_done  = amode_beat & last_beat;
   assign addr_out    = addr_q;

   always_comb begin
      rx_pkt_mod = bus.rx_packet_in;
      if (amode) begin
         rx_pkt_mod[AW+7:8] = addr_cur;
         rx_pkt_mod[0]      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.access_out <= 1'b0;
         bus.packet_out <= '0;
`ifndef MIO_SCHED_REGPRI_EN
         state          <= PRI_RX;
`endif
      end else if (load) begin
         bus.access_out <= rx_acc | reg_acc;
         if (rx_acc) begin
            bus.packet_out <= rx_pkt_mod;
         end else if (reg_acc) begin
            bus.packet_out <= bus.reg_packet_in;
         end
`ifndef MIO_SCHED_REGPRI_EN
         if (rx_acc) begin
            state <= PRI_REG;
         end else if (reg_acc) begin
            state <= PRI_RX;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         amode_q <= 1'b0;
         addr_q  <= '0;
         beat_q  <= '0;
      end else begin
         amode_q <= amode;
         if (burst_done) begin
            addr_q <= dstaddr_base;
            beat_q <= 16'd0;
         end else if (amode_beat) begin
            addr_q <= addr_cur + addr_step;
            beat_q <= beat_cur + 16'd1;
         end else if (first_amode) begin
            addr_q <= dstaddr_base;
            beat_q <= 16'd0;
         end
      end
   end

endmodule

// File: doc/mio_rx_sched.md
MIO_RX_SCHED -- requirements
Module: mio_rx_sched

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter PW, default 104, emesh packet width: [0] write, [2:1] datamode, [7:3] ctrlmode, [AW+7:8] dstaddr, [2AW+7:AW+8] data, [3AW+7:2AW+8] srcaddr.
REQ-003 clk  input  1  single core clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 amode  input  1  auto address mode enable.
REQ-006 dstaddr_base  input  AW  amode burst start address.
REQ-007 addr_stride  input  4  amode address increment per beat, in bytes.
REQ-008 burst_len  input  16  amode beats per burst; 0 = unbounded.
REQ-009 rx_access_in  input  1  rx datapath packet valid.
REQ-010 rx_packet_in  input  PW  rx datapath packet.
REQ-011 rx_wait_out  output  1  backpressure to rx datapath.
REQ-012 reg_access_in  input  1  register-response packet valid.
REQ-013 reg_packet_in  input  PW  register-response packet.
REQ-014 reg_wait_out  output  1  backpressure to register block.
REQ-015 access_out  output  1  packet valid to core.
REQ-016 packet_out  output  PW  packet to core.
REQ-017 wait_in  input  1  core backpressure.
REQ-018 addr_out  output  AW  current amode address counter.
REQ-019 burst_done  output  1  one-cycle pulse on last beat of an amode burst.

Function
REQ-020 The block SHALL share one core output port between rx and reg requesters through a single output register (access_out/packet_out).
REQ-021 The output register SHALL load when empty or when wait_in=0; a requester is accepted in a cycle iff it is granted, asserts access, and the register loads.
REQ-022 Latency SHALL be 1 cycle: packet accepted in cycle N appears on packet_out in cycle N+1.
REQ-023 While wait_in=1 and access_out=1, packet_out and access_out SHALL hold unchanged.
REQ-024 Grant state machine SHALL have states PRI_RX and PRI_REG; with both requesting, the prioritized requester wins and state moves to the other; with one requesting, it wins and state moves to the non-winner.
REQ-025 rx_wait_out SHALL be 1 when the register cannot load or rx is not granted; reg_wait_out likewise; both SHALL be combinational from current state, access inputs and wait_in.
REQ-026 In amode, accepted rx packets SHALL have dstaddr field replaced by addr_out, write bit forced to 1; reg packets SHALL pass unmodified in all modes.
REQ-027 Address counter SHALL load dstaddr_base on the first cycle amode is 1 after being 0, and advance by addr_stride (zero-extended, modulo 2^AW) per accepted amode rx beat.
REQ-028 Beat counter SHALL count accepted amode rx beats; when burst_len!=0 and the beat being accepted is beat burst_len-1, the block SHALL pulse burst_done that cycle and reload addr_out to dstaddr_base and beat count to 0 next cycle.
REQ-029 burst_len=1 SHALL pulse burst_done on every amode beat with address constant at dstaddr_base.
REQ-030 With amode=0, address and beat counters SHALL hold and burst_done SHALL be 0.

Reset
REQ-031 On reset: access_out=0, packet_out=0, state=PRI_RX, addr_out=0, beat count=0, burst_done=0; reset mid-transfer SHALL discard the held packet.
REQ-032 First amode cycle after reset SHALL load dstaddr_base.

Configuration
REQ-033 Macro MIO_SCHED_REGPRI_EN defined: fixed priority, reg always wins over rx, state machine removed; undefined: round-robin per REQ-024.

Verification
REQ-034 Both request every cycle, wait_in=0 -> grants alternate rx, reg, rx, reg starting with rx after reset (reg,reg,... with MIO_SCHED_REGPRI_EN).
REQ-035 wait_in=1 for 3 cycles with access_out=1 -> packet_out stable, rx_wait_out=reg_wait_out=1, no packet lost after release.
REQ-036 amode=1, base=0x8000_0000, stride=4, burst_len=3, 4 rx beats -> dstaddr fields 0x80000000, 0x80000004, 0x80000008, 0x80000000; burst_done on third beat.
REQ-037 amode=1, burst_len=0, base=0xFFFF_FFFC, stride=8 -> addresses 0xFFFFFFFC, 0x00000004; burst_done never asserts.
REQ-038 reset asserted while access_out=1, wait_in=1 -> next cycle access_out=0, addr_out=0, state PRI_RX.
